// File: rtl/ooo_pkg.sv
// Shared rename-stage types: register index widths and the physical tag type used by rat and phys_free_list.
package ooo_pkg;

  localparam int unsigned NUM_ARCH_REGS_DEF = 8;
  localparam int unsigned NUM_PHYS_REGS_DEF = 16;
  localparam int unsigned ARCH_REG_WIDTH    = $clog2(NUM_ARCH_REGS_DEF);
  localparam int unsigned PHYS_REG_WIDTH    = $clog2(NUM_PHYS_REGS_DEF);

  typedef logic [PHYS_REG_WIDTH-1:0] phys_reg_t;

endpackage

// File: rtl/phys_free_list.sv
// Physical-register free list: circular FIFO of tags plus an in-list bitmap for double-free detection.
// Optional FREE_LIST_BYPASS_EN forwards a release straight to the allocator when the list is empty.
module phys_free_list
  import ooo_pkg::*;
#(
  parameter int unsigned NUM_ARCH_REGS = NUM_ARCH_REGS_DEF,
  parameter int unsigned NUM_PHYS_REGS = NUM_PHYS_REGS_DEF
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             alloc_in_valid,
  output logic                             alloc_out_valid,
  output logic [$clog2(NUM_PHYS_REGS)-1:0] phys_reg_alloc_out,
  input  logic                             free_in_valid,
  input  logic [$clog2(NUM_PHYS_REGS)-1:0] phys_reg_free_in,
  output logic                             free_err,
  output logic [$clog2(NUM_PHYS_REGS):0]   free_count
);

  localparam int unsigned TW = $clog2(NUM_PHYS_REGS);
  localparam logic [TW:0]   FULL_C  = (TW+1)'(NUM_PHYS_REGS);
  localparam logic [TW:0]   CNT_ONE = (TW+1)'(1);
  localparam logic [TW-1:0] PTR_ONE = TW'(1);

  if ((NUM_PHYS_REGS < 2) || ((NUM_PHYS_REGS & (NUM_PHYS_REGS - 1)) != 0)) begin : g_bad_depth
    $error("phys_free_list: NUM_PHYS_REGS must be a power of two >= 2");
  end
  if (NUM_ARCH_REGS > NUM_PHYS_REGS) begin : g_bad_arch
    $error("phys_free_list: NUM_ARCH_REGS exceeds NUM_PHYS_REGS");
  end

  logic [TW-1:0]      mem_q [NUM_PHYS_REGS];
  logic [TW-1:0]      mem_d [NUM_PHYS_REGS];
  logic [TW-1:0]      head_q, head_d;
  logic [TW-1:0]      tail_q, tail_d;
  logic [TW:0]        count_q, count_d;
  logic [NUM_PHYS_REGS-1:0] in_list_q, in_list_d;
  logic               free_err_q, free_err_d;

  logic          empty, full;
  logic [TW-1:0] head_tag;
  logic          alloc_fire;
  logic          free_ok;
  logic          bypass;
  logic          bypass_take;

  assign empty    = (count_q == '0);
  assign full     = (count_q == FULL_C);
  assign head_tag = mem_q[head_q];
  assign alloc_fire = alloc_in_valid && !empty;

  // Releasing the tag being allocated this cycle is legal: its in_list bit is about to clear.
  assign free_ok = free_in_valid && !full &&
                   (!in_list_q[phys_reg_free_in] || (alloc_fire && (phys_reg_free_in == head_tag)));

`ifdef FREE_LIST_BYPASS_EN
  assign bypass = empty && free_ok;
`else
  assign bypass = 1'b0;
`endif
  assign bypass_take = bypass && alloc_in_valid;

  assign alloc_out_valid    = !empty || bypass;
  assign phys_reg_alloc_out = bypass ? phys_reg_free_in : head_tag;
  assign free_count         = count_q;
  assign free_err           = free_err_q;

  always_comb begin
    mem_d      = mem_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    in_list_d  = in_list_q;
    free_err_d = free_in_valid && !free_ok;

    if (alloc_fire) begin
      head_d              = head_q + PTR_ONE;
      in_list_d[head_tag] = 1'b0;
    end
    // Release is applied after allocate so a same-tag pair leaves the bit set.
    if (free_ok && !bypass_take) begin
      mem_d[tail_q]               = phys_reg_free_in;
      tail_d                      = tail_q + PTR_ONE;
      in_list_d[phys_reg_free_in] = 1'b1;
    end

    if ((free_ok && !bypass_take) && !alloc_fire) begin
      count_d = count_q + CNT_ONE;
    end else if (alloc_fire && !free_ok) begin
      count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_PHYS_REGS; i++) begin
        mem_q[i] <= TW'(i);
      end
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= FULL_C;
      in_list_q  <= '1;
      free_err_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      in_list_q  <= in_list_d;
      free_err_q <= free_err_d;
    end
  end

endmodule

// File: tb/tb_phys_free_list.sv
// Directed self-checking bench for phys_free_list (default 16-tag configuration).
module tb_phys_free_list;

  logic       clk;
  logic       rst;
  logic       alloc_in_valid;
  logic       alloc_out_valid;
  logic [3:0] phys_reg_alloc_out;
  logic       free_in_valid;
  logic [3:0] phys_reg_free_in;
  logic       free_err;
  logic [4:0] free_count;

  int unsigned n_checks;
  int unsigned n_pass;

  phys_free_list #(.NUM_ARCH_REGS(8), .NUM_PHYS_REGS(16)) dut (
    .clk                (clk),
    .rst                (rst),
    .alloc_in_valid     (alloc_in_valid),
    .alloc_out_valid    (alloc_out_valid),
    .phys_reg_alloc_out (phys_reg_alloc_out),
    .free_in_valid      (free_in_valid),
    .phys_reg_free_in   (phys_reg_free_in),
    .free_err           (free_err),
    .free_count         (free_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled at posedge+1, well away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; alloc_in_valid = 1'b0; free_in_valid = 1'b0; phys_reg_free_in = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic alloc_n(input int n);
    alloc_in_valid = 1'b1;
    for (int i = 0; i < n; i++) step();
    alloc_in_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (alloc_out_valid !== 1'b1) $display("FAIL reset_valid got=%b exp=1", alloc_out_valid); else n_pass++;
    n_checks++;
    if (phys_reg_alloc_out !== 4'd0) $display("FAIL reset_tag got=%0d exp=0", phys_reg_alloc_out); else n_pass++;
    n_checks++;
    if (free_count !== 5'd16) $display("FAIL reset_count got=%0d exp=16", free_count); else n_pass++;
    n_checks++;
    if (free_err !== 1'b0) $display("FAIL reset_err got=%b exp=0", free_err); else n_pass++;
  endtask

  task automatic test_drain();
    do_reset();
    alloc_in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (phys_reg_alloc_out !== 4'(i) || alloc_out_valid !== 1'b1)
        $display("FAIL drain_tag[%0d] got=%0d/%b exp=%0d/1", i, phys_reg_alloc_out, alloc_out_valid, i);
      else n_pass++;
      n_checks++;
      if (free_count !== 5'(16 - i)) $display("FAIL drain_count[%0d] got=%0d exp=%0d", i, free_count, 16 - i);
      else n_pass++;
      step();
    end
    n_checks++;
    if (free_count !== 5'd0 || alloc_out_valid !== 1'b0)
      $display("FAIL drain_empty got=%0d/%b exp=0/0", free_count, alloc_out_valid);
    else n_pass++;
    // Allocate while empty must leave the list untouched.
    step();
    alloc_in_valid = 1'b0;
    n_checks++;
    if (free_count !== 5'd0) $display("FAIL empty_alloc_count got=%0d exp=0", free_count); else n_pass++;
  endtask

  task automatic test_release_empty();
    free_in_valid = 1'b1; phys_reg_free_in = 4'd5;
    step();
    free_in_valid = 1'b0;
    n_checks++;
    if (alloc_out_valid !== 1'b1 || phys_reg_alloc_out !== 4'd5 || free_count !== 5'd1)
      $display("FAIL rel5_avail got=%b/%0d/%0d exp=1/5/1", alloc_out_valid, phys_reg_alloc_out, free_count);
    else n_pass++;
    n_checks++;
    if (free_err !== 1'b0) $display("FAIL rel5_err got=%b exp=0", free_err); else n_pass++;
    alloc_n(1);
    n_checks++;
    if (free_count !== 5'd0 || alloc_out_valid !== 1'b0)
      $display("FAIL rel5_consumed got=%0d/%b exp=0/0", free_count, alloc_out_valid);
    else n_pass++;
  endtask

  task automatic test_double_free();
    do_reset();
    free_in_valid = 1'b1; phys_reg_free_in = 4'd3;
    step();
    free_in_valid = 1'b0;
    n_checks++;
    if (free_err !== 1'b1) $display("FAIL dfree_err got=%b exp=1", free_err); else n_pass++;
    n_checks++;
    if (free_count !== 5'd16) $display("FAIL dfree_count got=%0d exp=16", free_count); else n_pass++;
    step();
    n_checks++;
    if (free_err !== 1'b0) $display("FAIL dfree_err_clear got=%b exp=0", free_err); else n_pass++;
  endtask

  task automatic test_same_cycle();
    do_reset();
    alloc_n(4);
    alloc_in_valid = 1'b1; free_in_valid = 1'b1; phys_reg_free_in = 4'd2;
    n_checks++;
    if (phys_reg_alloc_out !== 4'd4) $display("FAIL same_tag4 got=%0d exp=4", phys_reg_alloc_out); else n_pass++;
    step();
    alloc_in_valid = 1'b0; free_in_valid = 1'b0;
    n_checks++;
    if (free_count !== 5'd12 || free_err !== 1'b0)
      $display("FAIL same_count got=%0d/%b exp=12/0", free_count, free_err);
    else n_pass++;
    alloc_n(11);
    n_checks++;
    if (phys_reg_alloc_out !== 4'd2 || free_count !== 5'd1)
      $display("FAIL wrap_tag2 got=%0d/%0d exp=2/1", phys_reg_alloc_out, free_count);
    else n_pass++;
    // Releasing the tag that is being allocated in the same cycle is legal.
    do_reset();
    alloc_n(1);
    alloc_in_valid = 1'b1; free_in_valid = 1'b1; phys_reg_free_in = 4'd1;
    step();
    alloc_in_valid = 1'b0; free_in_valid = 1'b0;
    n_checks++;
    if (free_err !== 1'b0 || free_count !== 5'd15 || phys_reg_alloc_out !== 4'd2)
      $display("FAIL selfswap got=%b/%0d/%0d exp=0/15/2", free_err, free_count, phys_reg_alloc_out);
    else n_pass++;
    alloc_n(14);
    n_checks++;
    if (phys_reg_alloc_out !== 4'd1 || free_count !== 5'd1)
      $display("FAIL selfswap_requeue got=%0d/%0d exp=1/1", phys_reg_alloc_out, free_count);
    else n_pass++;
  endtask

  task automatic test_full_release();
    do_reset();
    alloc_in_valid = 1'b1; free_in_valid = 1'b1; phys_reg_free_in = 4'd0;
    step();
    alloc_in_valid = 1'b0; free_in_valid = 1'b0;
    n_checks++;
    if (free_err !== 1'b1 || free_count !== 5'd15)
      $display("FAIL full_release got=%b/%0d exp=1/15", free_err, free_count);
    else n_pass++;
  endtask

  task automatic test_bypass();
    do_reset();
    alloc_n(16);
    alloc_in_valid = 1'b1; free_in_valid = 1'b1; phys_reg_free_in = 4'd9;
`ifdef FREE_LIST_BYPASS_EN
    n_checks++;
    if (alloc_out_valid !== 1'b1 || phys_reg_alloc_out !== 4'd9)
      $display("FAIL bypass_comb got=%b/%0d exp=1/9", alloc_out_valid, phys_reg_alloc_out);
    else n_pass++;
    step();
    alloc_in_valid = 1'b0; free_in_valid = 1'b0;
    n_checks++;
    if (free_count !== 5'd0 || alloc_out_valid !== 1'b0)
      $display("FAIL bypass_after got=%0d/%b exp=0/0", free_count, alloc_out_valid);
    else n_pass++;
`else
    n_checks++;
    if (alloc_out_valid !== 1'b0) $display("FAIL nobypass_comb got=%b exp=0", alloc_out_valid); else n_pass++;
    step();
    alloc_in_valid = 1'b0; free_in_valid = 1'b0;
    n_checks++;
    if (free_count !== 5'd1 || alloc_out_valid !== 1'b1 || phys_reg_alloc_out !== 4'd9)
      $display("FAIL nobypass_after got=%0d/%b/%0d exp=1/1/9", free_count, alloc_out_valid, phys_reg_alloc_out);
    else n_pass++;
`endif
  endtask

  task automatic test_reset_mid();
    do_reset();
    alloc_n(7);
    n_checks++;
    if (free_count !== 5'd9 || phys_reg_alloc_out !== 4'd7)
      $display("FAIL mid_pre got=%0d/%0d exp=9/7", free_count, phys_reg_alloc_out);
    else n_pass++;
    // Double free of tag 10 in the reset cycle must not raise free_err.
    rst = 1'b1; alloc_in_valid = 1'b1; free_in_valid = 1'b1; phys_reg_free_in = 4'd10;
    step();
    idle_inputs();
    n_checks++;
    if (free_count !== 5'd16 || phys_reg_alloc_out !== 4'd0 || free_err !== 1'b0)
      $display("FAIL mid_reset got=%0d/%0d/%b exp=16/0/0", free_count, phys_reg_alloc_out, free_err);
    else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    idle_inputs();
    step();
    test_reset();
    test_drain();
    test_release_empty();
    test_double_free();
    test_same_cycle();
    test_full_release();
    test_bypass();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/phys_free_list.md
# phys_free_list

Physical-register free list for the rename stage: supplies the next free physical tag to the register alias table on every rename and reclaims tags released at commit. Circular FIFO of tags with a per-tag "in list" bitmap for double-free detection. Sits beside `rat`: the rename-time allocator is the consumer, and the commit/retire logic is the producer.

## Interface
- `NUM_ARCH_REGS`, 8, architectural register count. Used only for width consistency with `rat`.
- `NUM_PHYS_REGS`, 16, physical register count and FIFO depth. Must be a power of two, at least 2.
- `clk`  input  1  single clock; all state updates on the posedge.
- `rst`  input  1  synchronous, active-high reset.
- `alloc_in_valid`  input  1  rename requests a tag this cycle.
- `alloc_out_valid`  output  1  a tag is available; `phys_reg_alloc_out` is meaningful.
- `phys_reg_alloc_out`  output  $clog2(NUM_PHYS_REGS)  tag at the head of the list.
- `free_in_valid`  input  1  commit releases a tag this cycle.
- `phys_reg_free_in`  input  $clog2(NUM_PHYS_REGS)  tag being released.
- `free_err`  output  1  one-cycle pulse: the last release was rejected (double free, or list full).
- `free_count`  output  $clog2(NUM_PHYS_REGS)+1  number of tags currently in the list.

## Operation
- Storage: `mem[NUM_PHYS_REGS]` of tags; `head` and `tail` pointers, $clog2(NUM_PHYS_REGS) bits each, wrap naturally; `count` register; `in_list[NUM_PHYS_REGS]` bitmap.
- Reset: `mem[i]=i`, `head=0`, `tail=0`, `count=NUM_PHYS_REGS`, `in_list` all 1, `free_err=0`. So `alloc_out_valid=1`, `phys_reg_alloc_out=0`, `free_count=NUM_PHYS_REGS`.
- Allocate fires when `alloc_in_valid && count!=0`:
  - `head++`
  - `in_list[mem[head]]<=0`
- Release accepted when `free_in_valid && !in_list[phys_reg_free_in] && count!=NUM_PHYS_REGS`:
  - `mem[tail]<=phys_reg_free_in`
  - `tail++`
  - `in_list[phys_reg_free_in]<=1`
- Release rejected otherwise: list unchanged, `free_err<=1` for the next cycle.
- `count` next value: +1 on release only, -1 on allocate only, unchanged on both or neither.
- Allocate and release in the same cycle:
  - Both take effect.
  - If the released tag equals the tag being allocated, the release is legal: `in_list` ends at 1 and the tag is re-enqueued at the tail.
- Allocate requested while empty: no state change. `alloc_out_valid=0` tells the RAT to stall the rename.
- Out-of-range tags cannot occur by width; no check.

## Timing
- `alloc_out_valid`, `phys_reg_alloc_out` and `free_count` are combinational from registered state.
- The tag is presented in the same cycle it is requested. The RAT samples it before the posedge, and the head advances at the posedge.
- A released tag becomes allocatable the cycle after release, or the same cycle under bypass (see Configuration).
- `free_err` is registered: asserted exactly one cycle after the offending release, deasserted otherwise.
- Reset mid-operation discards all pending state and restores the full list on the next posedge. Inputs in the reset cycle are ignored.

## Configuration
- `FREE_LIST_BYPASS_EN` defined: when `count==0` and an accepted release occurs, bypass the list:
  - `alloc_out_valid=1` and `phys_reg_alloc_out=phys_reg_free_in` combinationally.
  - If `alloc_in_valid` is also high, the tag goes straight to the allocator. It is not written to `mem`, pointers are unchanged, `count` stays 0, and `in_list` stays 0.
- `FREE_LIST_BYPASS_EN` undefined: an empty list always reports `alloc_out_valid=0`, and a same-cycle release is enqueued normally.

## Structure
- Shared package `ooo_pkg`:
  - `ARCH_REG_WIDTH` and `PHYS_REG_WIDTH` localparams.
  - `phys_reg_t` typedef, shared with `rat`.
- Single flat module; no sub-module. The FIFO and bitmap are too tightly coupled to split.

## Test plan
- Reset, then allocate 16 times back-to-back -> tags 0..15 in order. `free_count` goes 16→0, then `alloc_out_valid=0`.
- Empty, release T5, allocate next cycle -> `phys_reg_alloc_out=5`, `free_count` 1→0.
- Release T3 while T3 is still in the list (right after reset) -> `free_err` high for one cycle, `free_count` stays 16.
- Allocate T0..T3, then release T2 and allocate T4 in the same cycle -> `free_count=12`. After wrap, T2 is returned following T15.
- Empty, release T9 with `alloc_in_valid` high:
  - With `FREE_LIST_BYPASS_EN`: `alloc_out_valid=1`, tag 9 in that cycle, `free_count` stays 0.
  - Without it: `alloc_out_valid=0`, tag 9 returned next cycle.
- Assert `rst` mid-stream after 7 allocations -> next cycle `free_count=16`, `phys_reg_alloc_out=0`, `free_err=0`.
